// File: rtl/clk_div_pkg.sv
// Shared constants, divisor type and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int PKG_DIV_W   = 8;
    localparam int PKG_DEF_DIV = 3;
    localparam int PKG_MIN_DIV = 2;

    typedef logic [PKG_DIV_W-1:0] div_t;

    // floor(N/2): number of whole clk_in cycles clk_out stays high
    function automatic div_t half_of(div_t n);
        return n >> 1;
    endfunction

    // Divisors below the minimum would give a degenerate output
    function automatic div_t clamp_div(div_t n);
        return (n < div_t'(PKG_MIN_DIV)) ? div_t'(PKG_MIN_DIV) : n;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Ratio-change handshake between a control agent (master) and the divider (slave).
interface clk_div_prog_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = PKG_DIV_W
);
    logic             div_req;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;
    logic             div_busy;
    logic [DIV_W-1:0] cur_div;

    modport master (output div_req, div_val, input div_ack, div_busy, cur_div);
    modport slave  (input div_req, div_val, output div_ack, div_busy, cur_div);
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Accepts a new divisor over req/ack and swaps it in only on a period wrap.
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = PKG_DIV_W,
    parameter int DEF_DIV = PKG_DEF_DIV,
    parameter int MIN_DIV = PKG_MIN_DIV
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             wrap_i,
    input  logic             div_req_i,
    input  logic [DIV_W-1:0] div_val_i,
    output logic             div_ack_o,
    output logic             div_busy_o,
    output logic [DIV_W-1:0] cur_div_o
);
    localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);

    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cur_q, cur_d;

    // Apply a pending value at the wrap; otherwise capture a fresh request.
    // A capture never applies on the same edge, so a request arriving in the
    // boundary cycle waits a full old period. The ack cycle itself ignores
    // div_req because the requester only drops it one cycle later.
    always_comb begin
        busy_d = busy_q;
        ack_d  = 1'b0;
        pend_d = pend_q;
        cur_d  = cur_q;
        if (busy_q && wrap_i) begin
            cur_d  = pend_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end else if (!busy_q && !ack_q && div_req_i) begin
            pend_d = (div_val_i < MIN_V) ? MIN_V : div_val_i;
            busy_d = 1'b1;
        end
    end

    // Handshake and active-divisor state
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            pend_q <= DEF_V;
            cur_q  <= DEF_V;
        end else begin
            busy_q <= busy_d;
            ack_q  <= ack_d;
            pend_q <= pend_d;
            cur_q  <= cur_d;
        end
    end

    assign div_ack_o  = ack_q;
    assign div_busy_o = busy_q;
    assign cur_div_o  = cur_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with glitch-free ratio change.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = PKG_DIV_W,
    parameter int DEF_DIV = PKG_DEF_DIV,
    parameter int MIN_DIV = PKG_MIN_DIV
) (
    input  logic           clk_in,
    input  logic           rst_n,
    clk_div_prog_if.slave  bus,
    output logic           tick,
    output logic           clk_out
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] half;
    logic             wrap;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             tick_q, tick_d;

    clk_div_ratio_ctrl #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .MIN_DIV (MIN_DIV)
    ) u_ctrl (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .wrap_i     (wrap),
        .div_req_i  (bus.div_req),
        .div_val_i  (bus.div_val),
        .div_ack_o  (bus.div_ack),
        .div_busy_o (bus.div_busy),
        .cur_div_o  (cur_div)
    );

    assign bus.cur_div = cur_div;
    assign half        = cur_div >> 1;

    // Next count and the high-phase decision for the cycle it starts.
    // On a wrap cnt_d is 0, which is below half for any legal divisor,
    // so using the old divisor's half here is safe across a change.
    always_comb begin
        wrap   = (cnt_q == cur_div - 1'b1);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pos_d  = (cnt_d < half);
        tick_d = wrap;
    end

    // Period counter, posedge phase of clk_out and period tick
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

    // Half-cycle delayed copy of pos_q stretches odd-ratio high phase by 0.5
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= pos_q;
    end

    // neg_q is always low at a wrap, so cur_div[0] changing there is harmless
    assign clk_out = pos_q | (neg_q & cur_div[0]);
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench: directed and random ratio changes against a period-level model.
module tb_clk_div_prog;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick, clk_out;

    clk_div_prog_if #(.DIV_W(8)) bus ();

    clk_div_prog dut (
        .clk_in  (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int acks  = 0;

    // Reference state: position in the current output period, active and
    // pending divisors, and whether a full period has been seen since reset.
    int m_cnt, m_cur, m_pend;
    bit m_busy, m_ack, m_live;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Output is high for floor(N/2) cycles, plus the first half of the next
    // cycle when N is odd, starting at the period boundary.
    function automatic bit hi_first(int k, int n);
        return (k < n / 2) || ((n % 2 == 1) && (k == n / 2));
    endfunction

    function automatic bit hi_second(int k, int n);
        return k < n / 2;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_cur  = 3;
        m_pend = 3;
        m_busy = 0;
        m_ack  = 0;
        m_live = 0;
    endtask

    task automatic step();
        bit req = bus.div_req;
        int val = int'(bus.div_val);
        bit pack, wrap;
        @(posedge clk);
        #1;
        pack  = m_ack;
        m_ack = 0;
        wrap  = (m_cnt == m_cur - 1);
        if (m_busy && wrap) begin
            m_cur  = m_pend;
            m_busy = 0;
            m_ack  = 1;
        end else if (!m_busy && !pack && req) begin
            m_pend = clampv(val);
            m_busy = 1;
        end
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap) m_live = 1;
        if (bus.div_ack === 1'b1) acks++;
        chk("tick", tick, m_cnt == 0);
        chk("div_ack", bus.div_ack, m_ack);
        chk("div_busy", bus.div_busy, m_busy);
        chk("cur_div", bus.cur_div, m_cur);
        if (m_live) chk("clk_out_hi_half", clk_out, hi_first(m_cnt, m_cur));
        @(negedge clk);
        #1;
        if (m_live) chk("clk_out_lo_half", clk_out, hi_second(m_cnt, m_cur));
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic run_to_cnt(int c);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (m_cnt == c) ok = 1;
            else step();
        end
        chk("reach_cnt_timeout", ok, 1);
    endtask

    task automatic req_and_wait(int val, int bound);
        bit ok = 0;
        bus.div_req = 1'b1;
        bus.div_val = 8'(val);
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (m_ack) ok = 1;
        end
        chk("ack_timeout", ok, 1);
        bus.div_req = 1'b0;
    endtask

    initial begin
        bus.div_req = 1'b0;
        bus.div_val = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", bus.div_busy, 0);
        chk("rst_ack", bus.div_ack, 0);
        chk("rst_cur_div", bus.cur_div, 3);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // default ratio 3
        run(12);

        // 3 -> 4, request seen while cnt=1
        run_to_cnt(1);
        req_and_wait(4, 20);
        run(12);

        // 4 -> 5 -> 2, odd/even transitions
        req_and_wait(5, 20);
        run(15);
        req_and_wait(2, 20);
        run(10);

        // clamping and the widest ratio
        req_and_wait(0, 20);
        run(6);
        chk("clamp0", bus.cur_div, 2);
        req_and_wait(1, 20);
        run(6);
        chk("clamp1", bus.cur_div, 2);
        req_and_wait(255, 20);
        run(520);
        req_and_wait(5, 600);
        run(5);

        // request first seen in the boundary cycle, value churn while busy
        run_to_cnt(4);
        acks = 0;
        bus.div_req = 1'b1;
        bus.div_val = 8'd7;
        step();
        begin
            bit ok = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                bus.div_val = 8'($urandom_range(0, 12));
                step();
                if (m_ack) ok = 1;
            end
            chk("boundary_ack_timeout", ok, 1);
        end
        bus.div_req = 1'b0;
        run(10);
        chk("boundary_one_ack", acks, 1);
        chk("boundary_cur_div", bus.cur_div, 7);

        // reset while a request is pending
        run_to_cnt(0);
        bus.div_req = 1'b1;
        bus.div_val = 8'd6;
        step();
        step();
        chk("busy_before_rst", bus.div_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        bus.div_req = 1'b0;
        chk("midrst_clk_out", clk_out, 0);
        chk("midrst_busy", bus.div_busy, 0);
        chk("midrst_ack", bus.div_ack, 0);
        chk("midrst_cur_div", bus.cur_div, 3);
        chk("midrst_tick", tick, 0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("inrst_ack", bus.div_ack, 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        run(15);

        // random requests, holds and ignored churn while busy
        for (int i = 0; i < 400; i++) begin
            if (!bus.div_req && !m_busy && $urandom_range(0, 3) == 0) begin
                bus.div_req = 1'b1;
                bus.div_val = 8'($urandom_range(0, 11));
            end
            step();
            if (bus.div_req && m_ack) bus.div_req = 1'b0;
            else if (m_busy && $urandom_range(0, 2) == 0) bus.div_val = 8'($urandom_range(0, 255));
        end
        bus.div_req = 1'b0;
        run(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
